// File: rtl/keypad_emulator_if.sv
// keypad_emulator_if
//   Command channel between a host and the keypad emulator.
//
//   Handshake: the host drives cmd_valid together with cmd_key, cmd_hold and
//   cmd_bounce. A command transfers on a rising clock edge where both
//   cmd_valid and cmd_ready are high. While cmd_ready is low, the emulator
//   ignores cmd_valid and the payload, so the host may change them freely.
//
//   Signals:
//     cmd_valid   host -> emulator  command offered
//     cmd_ready   emulator -> host  emulator idle
//     cmd_key     host -> emulator  key index {row[1:0], col[1:0]}
//     cmd_hold    host -> emulator  hold time in ticks (0 behaves as 1)
//     cmd_bounce  host -> emulator  1 = play contact chatter on press/release
interface keypad_emulator_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_key;
    logic [7:0] cmd_hold;
    logic       cmd_bounce;

    modport master (
        output cmd_valid, cmd_key, cmd_hold, cmd_bounce,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_key, cmd_hold, cmd_bounce,
        output cmd_ready
    );
endinterface

// File: rtl/keypad_emulator.sv
// keypad_emulator
//   Emulates one key of a 4x4 matrix keypad on a scanner's row/column pins.
//   A host command plays a press (optional chatter), holds the contact for a
//   number of ticks, releases it (optional chatter), enforces a released gap
//   and then pulses done.
//
//   Ports:
//     clk, rst_n  clock, asynchronous active-low reset
//     cmd         command channel (keypad_emulator_if.slave)
//     cols        column strobes from the scanner, active high
//     rows        emulated row sense, active high, registered
//     contact     emulated contact state (1 = closed), registered
//     done        one-cycle pulse in the first idle cycle after a sequence
//     state_o     current FSM state, for observation
module keypad_emulator #(
    parameter int unsigned TICK_DIV   = 256,
    parameter int unsigned BOUNCE_LEN = 16,
    parameter int unsigned GAP_TICKS  = 4,
    parameter logic [7:0]  LFSR_SEED  = 8'hA5
) (
    input  logic              clk,
    input  logic              rst_n,
    keypad_emulator_if.slave  cmd,
    input  logic [3:0]        cols,
    output logic [3:0]        rows,
    output logic              contact,
    output logic              done,
    output logic [2:0]        state_o
);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        BOUNCE_IN  = 3'd1,
        HELD       = 3'd2,
        BOUNCE_OUT = 3'd3,
        GAP        = 3'd4
    } state_t;

    // One counter serves as tick prescaler and as bounce-phase cycle counter.
    localparam int unsigned PMAX = (TICK_DIV > BOUNCE_LEN) ? TICK_DIV : BOUNCE_LEN;
    localparam int unsigned CW   = $clog2(PMAX + 1);

    state_t          state_q, state_d;
    logic [CW-1:0]   presc_q, presc_d;
    logic [7:0]      tick_q, tick_d;
    logic [3:0]      key_q, key_d;
    logic [7:0]      hold_q, hold_d;
    logic            bounce_q, bounce_d;
    logic [7:0]      lfsr_q, lfsr_d;
    logic            contact_q, contact_d;
    logic [3:0]      rows_q, rows_d;
    logic            done_q, done_d;

    logic            tick_end;
    logic            bounce_end;
    logic            in_bounce_d;

    assign tick_end   = (presc_q == CW'(TICK_DIV - 1));
    assign bounce_end = (presc_q == CW'(BOUNCE_LEN - 1));

    always_comb begin
        state_d  = state_q;
        presc_d  = presc_q + 1'b1;
        tick_d   = tick_q;
        key_d    = key_q;
        hold_d   = hold_q;
        bounce_d = bounce_q;

        case (state_q)
            IDLE: begin
                presc_d = '0;
                if (cmd.cmd_valid) begin
                    key_d    = cmd.cmd_key;
                    hold_d   = (cmd.cmd_hold == 8'd0) ? 8'd1 : cmd.cmd_hold;
                    bounce_d = cmd.cmd_bounce;
                    state_d  = cmd.cmd_bounce ? BOUNCE_IN : HELD;
                end
            end
            BOUNCE_IN: begin
                if (bounce_end) state_d = HELD;
            end
            HELD: begin
                if (tick_end) begin
                    presc_d = '0;
                    tick_d  = tick_q + 8'd1;
                    if (tick_q == 8'(hold_q - 8'd1))
                        state_d = bounce_q ? BOUNCE_OUT : GAP;
                end
            end
            BOUNCE_OUT: begin
                if (bounce_end) state_d = GAP;
            end
            GAP: begin
                if (tick_end) begin
                    presc_d = '0;
                    tick_d  = tick_q + 8'd1;
                    if (tick_q == 8'(GAP_TICKS - 1)) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Every state starts its timing from zero.
        if (state_d != state_q) begin
            presc_d = '0;
            tick_d  = 8'd0;
        end
    end

    // contact is registered from the next-state decode so it changes in the
    // same cycle the new state becomes visible. The LFSR steps only on edges
    // that land in a bounce state, so each bounce cycle sees a fresh bit.
    always_comb begin
        in_bounce_d = (state_d == BOUNCE_IN) || (state_d == BOUNCE_OUT);
        lfsr_d      = lfsr_q;
        if (in_bounce_d)
            lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        contact_d = in_bounce_d ? lfsr_q[0] : (state_d == HELD);
        done_d    = (state_q == GAP) && (state_d == IDLE);
    end

    // Only the addressed row responds, and only to its own column.
    always_comb begin
        rows_d = 4'b0000;
        for (int r = 0; r < 4; r++)
            rows_d[r] = contact_q && (key_q[3:2] == 2'(r)) && cols[key_q[1:0]];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            presc_q   <= '0;
            tick_q    <= 8'd0;
            key_q     <= 4'd0;
            hold_q    <= 8'd1;
            bounce_q  <= 1'b0;
            lfsr_q    <= LFSR_SEED;
            contact_q <= 1'b0;
            rows_q    <= 4'b0000;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            tick_q    <= tick_d;
            key_q     <= key_d;
            hold_q    <= hold_d;
            bounce_q  <= bounce_d;
            lfsr_q    <= lfsr_d;
            contact_q <= contact_d;
            rows_q    <= rows_d;
            done_q    <= done_d;
        end
    end

    assign cmd.cmd_ready = (state_q == IDLE);
    assign rows          = rows_q;
    assign contact       = contact_q;
    assign done          = done_q;
    assign state_o       = state_q;

endmodule

// File: tb/tb_keypad_emulator.sv
module tb_keypad_emulator;

    localparam int TD = 4;
    localparam int BL = 8;
    localparam int GT = 1;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] cols = 4'b0000;
    logic [3:0] rows;
    logic       contact;
    logic       done;
    logic [2:0] state_dbg;

    keypad_emulator_if cmd_if ();

    keypad_emulator #(
        .TICK_DIV   (TD),
        .BOUNCE_LEN (BL),
        .GAP_TICKS  (GT),
        .LFSR_SEED  (8'hA5)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .cmd     (cmd_if),
        .cols    (cols),
        .rows    (rows),
        .contact (contact),
        .done    (done),
        .state_o (state_dbg)
    );

    always #5 clk = ~clk;

    // ---------------- reference model state ----------------
    int         checks = 0;
    int         errors = 0;
    logic [7:0] lfsr_m;
    logic       prev_contact;
    logic [3:0] prev_cols;
    logic [3:0] key_m;
    int         cols_mode;
    int         cyc;

    function automatic logic [7:0] lfsr_next(input logic [7:0] l);
        // polynomial x^8+x^6+x^5+x^4+1 -> parity of bits 7,5,4,3
        return {l[6:0], ^(l & 8'hB8)};
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_cols();
        case (cols_mode)
            0:       cols = 4'(4'b0001 << ((cyc / 2) % 4));
            1:       cols = 4'b1111;
            default: cols = 4'($urandom_range(0, 15));
        endcase
        prev_cols = cols;
        cyc++;
    endtask

    // One cycle: sample outputs on the falling edge, compare, drive next cols.
    task automatic tick_check(input logic exp_contact, input logic exp_done, input logic exp_ready);
        logic [3:0] exp_rows;
        @(negedge clk);
        exp_rows = 4'b0000;
        if (prev_contact && prev_cols[key_m[1:0]]) exp_rows[key_m[3:2]] = 1'b1;
        check_val("contact", {31'd0, contact}, {31'd0, exp_contact});
        check_val("done", {31'd0, done}, {31'd0, exp_done});
        check_val("cmd_ready", {31'd0, cmd_if.cmd_ready}, {31'd0, exp_ready});
        check_val("rows", {28'd0, rows}, {28'd0, exp_rows});
        prev_contact = exp_contact;
        drive_cols();
    endtask

    task automatic offer(input logic [3:0] key, input logic [7:0] hold, input logic bnc);
        cmd_if.cmd_valid  = 1'b1;
        cmd_if.cmd_key    = key;
        cmd_if.cmd_hold   = hold;
        cmd_if.cmd_bounce = bnc;
    endtask

    // Called at the falling edge before the accepting edge. Builds the whole
    // expected contact waveform, then checks it cycle by cycle, ending in the
    // done cycle. With chain set, the next command is offered during the busy
    // period and stays valid into the done cycle.
    task automatic run_cmd(input logic [3:0] key, input logic [7:0] hold, input logic bnc,
                           input bit chain, input logic [3:0] nkey, input logic [7:0] nhold,
                           input logic nbnc, input int abort_at);
        logic [0:0] exp_q[$];
        int h;
        h = (hold == 8'd0) ? 1 : int'(hold);
        exp_q = {};
        if (bnc) for (int k = 0; k < BL; k++) begin
            exp_q.push_back(lfsr_m[0]);
            lfsr_m = lfsr_next(lfsr_m);
        end
        for (int k = 0; k < h * TD; k++) exp_q.push_back(1'b1);
        if (bnc) for (int k = 0; k < BL; k++) begin
            exp_q.push_back(lfsr_m[0]);
            lfsr_m = lfsr_next(lfsr_m);
        end
        for (int k = 0; k < GT * TD; k++) exp_q.push_back(1'b0);
        key_m = key;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i == abort_at) return;
            tick_check(exp_q[i], 1'b0, 1'b0);
            if (i == 0) begin
                if (chain) offer(nkey, nhold, nbnc);
                else cmd_if.cmd_valid = 1'b0;
            end
        end
        tick_check(1'b0, 1'b1, 1'b1);
    endtask

    task automatic full_cmd(input logic [3:0] key, input logic [7:0] hold, input logic bnc);
        offer(key, hold, bnc);
        run_cmd(key, hold, bnc, 1'b0, 4'd0, 8'd0, 1'b0, -1);
        tick_check(1'b0, 1'b0, 1'b1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        cmd_if.cmd_valid  = 1'b0;
        cmd_if.cmd_key    = 4'd0;
        cmd_if.cmd_hold   = 8'd0;
        cmd_if.cmd_bounce = 1'b0;
        lfsr_m       = 8'hA5;
        prev_contact = 1'b0;
        prev_cols    = 4'b0000;
        key_m        = 4'd0;
        cols_mode    = 0;
        cyc          = 0;

        // reset state, mid-clock
        #12;
        check_val("rst_contact", {31'd0, contact}, 32'd0);
        check_val("rst_rows", {28'd0, rows}, 32'd0);
        check_val("rst_done", {31'd0, done}, 32'd0);
        check_val("rst_ready", {31'd0, cmd_if.cmd_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) tick_check(1'b0, 1'b0, 1'b1);

        // plain press, scanner walking one-hot columns
        cols_mode = 0;
        full_cmd(4'd6, 8'd3, 1'b0);

        // same press with chatter
        full_cmd(4'd6, 8'd3, 1'b1);

        // hold=0 behaves as hold=1; all columns driven
        cols_mode = 1;
        full_cmd(4'd15, 8'd0, 1'b0);
        full_cmd(4'd15, 8'd1, 1'b0);

        // second command held valid while busy, accepted in the done cycle
        cols_mode = 2;
        offer(4'd9, 8'd2, 1'b1);
        run_cmd(4'd9, 8'd2, 1'b1, 1'b1, 4'd3, 8'd1, 1'b0, -1);
        run_cmd(4'd3, 8'd1, 1'b0, 1'b0, 4'd0, 8'd0, 1'b0, -1);
        tick_check(1'b0, 1'b0, 1'b1);

        // async reset while HELD
        cols_mode = 1;
        offer(4'd5, 8'd4, 1'b0);
        run_cmd(4'd5, 8'd4, 1'b0, 1'b0, 4'd0, 8'd0, 1'b0, 6);
        #1 rst_n = 1'b0;
        #1;
        check_val("arst_contact", {31'd0, contact}, 32'd0);
        check_val("arst_rows", {28'd0, rows}, 32'd0);
        check_val("arst_done", {31'd0, done}, 32'd0);
        check_val("arst_ready", {31'd0, cmd_if.cmd_ready}, 32'd1);
        @(negedge clk);
        rst_n        = 1'b1;
        lfsr_m       = 8'hA5;
        prev_contact = 1'b0;
        prev_cols    = cols;
        for (int i = 0; i < 10; i++) tick_check(1'b0, 1'b0, 1'b1);
        full_cmd(4'd5, 8'd2, 1'b1);

        // randomized commands
        for (int n = 0; n < 12; n++) begin
            cols_mode = int'($urandom_range(0, 2));
            full_cmd(4'($urandom_range(0, 15)), 8'($urandom_range(0, 6)), 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
